// File: rtl/rca_accumulator.sv
// Purpose: sums NSAMP {cout,sum} results from an upstream ripple-carry adder into one 8-bit frame result.
// Latency: out_valid rises on the cycle after the transfer that completes the frame.
// Backpressure: the finished frame is held and in_ready stays low until out_ready; clear/reset abort the frame.
module rca_accumulator #(
  parameter int NSAMP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [3:0] sum,
  input  logic       cout,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] acc_out,
  output logic       overflow,
  output logic [3:0] count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Count width is 4 bits, which limits a frame to 15 results.
  localparam logic [3:0] LP_NSAMP = 4'(NSAMP);

  logic [1:0] r_state;
  logic [7:0] r_acc;
  logic       r_ovf;
  logic [3:0] r_count;

  logic       w_xfer;
  logic [4:0] w_operand;
  logic [8:0] w_sum9;
  logic [3:0] w_count_nxt;
  logic       w_frame_done;

  // Input acceptance is purely combinational so a clear or reset blocks the transfer on the same edge.
  always_comb begin
    in_ready = 1'b0;
    if (!reset && !clear && (r_state != ST_HOLD)) begin
      in_ready = 1'b1;
    end
  end

  assign w_xfer       = in_valid && in_ready;
  assign w_operand    = {cout, sum};
  // A 9-bit sum exposes the carry out of the 8-bit accumulator for overflow detection.
  assign w_sum9       = {1'b0, r_acc} + {4'b0000, w_operand};
  assign w_count_nxt  = r_count + 4'd1;
  assign w_frame_done = (w_count_nxt == LP_NSAMP);

  // Frame state machine: reset beats clear, clear beats every handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_acc   <= 8'd0;
      r_ovf   <= 1'b0;
      r_count <= 4'd0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_acc   <= 8'd0;
      r_ovf   <= 1'b0;
      r_count <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            // First result of a frame loads rather than adds; it cannot overflow.
            r_acc   <= {3'b000, w_operand};
            r_ovf   <= 1'b0;
            r_count <= 4'd1;
            r_state <= (LP_NSAMP == 4'd1) ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_sum9[7:0];
            r_ovf   <= r_ovf | w_sum9[8];
            r_count <= w_count_nxt;
            if (w_frame_done) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Result is frozen until the consumer takes it; the next frame starts from zero.
          if (out_ready) begin
            r_state <= ST_IDLE;
            r_acc   <= 8'd0;
            r_ovf   <= 1'b0;
            r_count <= 4'd0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_acc   <= 8'd0;
          r_ovf   <= 1'b0;
          r_count <= 4'd0;
        end
      endcase
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;
  assign count     = r_count;

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator: NSAMP=4 table plus hand sequences for NSAMP=15, NSAMP=1 and reset aborts.
module tb_rca_accumulator;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, cout, out_ready;
  logic [3:0] sum;

  logic       rdy4, ovld4, ovf4;
  logic [7:0] acc4;
  logic [3:0] cnt4;
  logic       rdy15, ovld15, ovf15;
  logic [7:0] acc15;
  logic [3:0] cnt15;
  logic       rdy1, ovld1, ovf1;
  logic [7:0] acc1;
  logic [3:0] cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rca_accumulator #(.NSAMP(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(rdy4), .out_ready(out_ready), .out_valid(ovld4), .acc_out(acc4),
    .overflow(ovf4), .count(cnt4));

  rca_accumulator #(.NSAMP(15)) dut15 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(rdy15), .out_ready(out_ready), .out_valid(ovld15), .acc_out(acc15),
    .overflow(ovf15), .count(cnt15));

  rca_accumulator #(.NSAMP(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .sum(sum), .cout(cout),
    .in_ready(rdy1), .out_ready(out_ready), .out_valid(ovld1), .acc_out(acc1),
    .overflow(ovf1), .count(cnt1));

  typedef struct {
    logic       v;
    logic       c;
    logic [3:0] s;
    logic       clr;
    logic       ordy;
    logic       e_rdy;
    logic       e_ovld;
    logic [7:0] e_acc;
    logic       e_ovf;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge so they are settled well before the next rising edge.
  task automatic drive(input logic v, input logic c, input logic [3:0] s,
                       input logic clr, input logic ordy, input logic rst);
    @(negedge clk);
    in_valid  = v;
    cout      = c;
    sum       = s;
    clear     = clr;
    out_ready = ordy;
    reset     = rst;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
    check("rdy_during_reset", rdy4, 0);
    edge_settle();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_dut4_zero(input string tag);
    check({tag, "_ovld"}, ovld4, 0);
    check({tag, "_acc"},  acc4,  0);
    check({tag, "_ovf"},  ovf4,  0);
    check({tag, "_cnt"},  cnt4,  0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; cout = 1'b0; sum = 4'h0; out_ready = 1'b0;

    //             v    c    s     clr  ordy rdy  ovld acc    ovf  cnt
    tbl[0]  = '{1'b1,1'b0,4'h3,1'b0,1'b0,1'b1,1'b0,8'h03,1'b0,4'd1};
    tbl[1]  = '{1'b1,1'b1,4'h9,1'b0,1'b0,1'b1,1'b0,8'h1C,1'b0,4'd2};
    tbl[2]  = '{1'b1,1'b0,4'h5,1'b0,1'b0,1'b1,1'b0,8'h21,1'b0,4'd3};
    tbl[3]  = '{1'b1,1'b1,4'h0,1'b0,1'b0,1'b1,1'b1,8'h31,1'b0,4'd4};
    tbl[4]  = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b0,1'b1,8'h31,1'b0,4'd4};
    tbl[5]  = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b0,1'b1,8'h31,1'b0,4'd4};
    tbl[6]  = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b0,1'b1,8'h31,1'b0,4'd4};
    tbl[7]  = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b0,1'b1,8'h31,1'b0,4'd4};
    tbl[8]  = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b0,1'b1,8'h31,1'b0,4'd4};
    tbl[9]  = '{1'b1,1'b1,4'hF,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,4'd0};
    tbl[10] = '{1'b0,1'b1,4'hA,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,4'd0};
    tbl[11] = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b1,1'b0,8'h1F,1'b0,4'd1};
    tbl[12] = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b1,1'b0,8'h3E,1'b0,4'd2};
    tbl[13] = '{1'b1,1'b1,4'hF,1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,4'd0};
    tbl[14] = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b1,1'b0,8'h1F,1'b0,4'd1};
    tbl[15] = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b1,1'b0,8'h3E,1'b0,4'd2};
    tbl[16] = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b1,1'b0,8'h5D,1'b0,4'd3};
    tbl[17] = '{1'b1,1'b1,4'hF,1'b0,1'b0,1'b1,1'b1,8'h7C,1'b0,4'd4};
    tbl[18] = '{1'b1,1'b1,4'hF,1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,4'd0};

    // Reset state of every instance.
    do_reset();
    check_dut4_zero("reset4");
    check("reset15_ovld", ovld15, 0);
    check("reset15_cnt",  cnt15,  0);
    check("reset1_ovld",  ovld1,  0);
    check("reset1_acc",   acc1,   0);
    check("idle_rdy",     rdy4,   1);

    // NSAMP=4 table: frame, backpressure, release, clear mid-frame, clear in HOLD.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].s, tbl[i].clr, tbl[i].ordy, 1'b0);
      check($sformatf("tbl%0d_rdy", i), rdy4, tbl[i].e_rdy);
      edge_settle();
      check($sformatf("tbl%0d_ovld", i), ovld4, tbl[i].e_ovld);
      check($sformatf("tbl%0d_acc", i),  acc4,  tbl[i].e_acc);
      check($sformatf("tbl%0d_ovf", i),  ovf4,  tbl[i].e_ovf);
      check($sformatf("tbl%0d_cnt", i),  cnt4,  tbl[i].e_cnt);
    end

    // NSAMP=15: fifteen 31s; overflow must first appear on the 9th transfer (279).
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
      edge_settle();
      check($sformatf("n15_acc_%0d", k),  acc15,  (k * 31) % 256);
      check($sformatf("n15_ovf_%0d", k),  ovf15,  (k * 31 > 255) ? 1 : 0);
      check($sformatf("n15_cnt_%0d", k),  cnt15,  k);
      check($sformatf("n15_ovld_%0d", k), ovld15, (k == 15) ? 1 : 0);
    end
    check("n15_final_acc", acc15, 8'hD1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    edge_settle();
    check("n15_hold_ovf", ovf15, 1);
    check("n15_hold_acc", acc15, 8'hD1);

    // Reset in ACCUM with count=3 discards the frame.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
      edge_settle();
    end
    check("mid_cnt_before", cnt4, 3);
    check("mid_acc_before", acc4, 21);
    do_reset();
    check_dut4_zero("mid_rst");
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      edge_settle();
      check($sformatf("mid_idle_ovld_%0d", k), ovld4, 0);
    end

    // Reset in HOLD, even with out_ready already high, leaves no result behind.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
      edge_settle();
    end
    check("hold_ovld_before", ovld4, 1);
    check("hold_acc_before",  acc4,  8);
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1);
    check("hold_rst_rdy", rdy4, 0);
    edge_settle();
    check_dut4_zero("hold_rst");
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      edge_settle();
      check($sformatf("hold_idle_ovld_%0d", k), ovld4, 0);
    end

    // NSAMP=1: a single transfer completes the frame.
    do_reset();
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    check("n1_rdy", rdy1, 1);
    edge_settle();
    check("n1_ovld", ovld1, 1);
    check("n1_acc",  acc1,  8'h1F);
    check("n1_cnt",  cnt1,  1);
    check("n1_ovf",  ovf1,  0);
    check("n1_hold_rdy", rdy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
